// File: rtl/rrp_stream_merger.sv
// N-channel round-robin word merger feeding an sram_fifo write port.
// Bounded bursts, channel enable mask, optional source-ID tag, saturating word counter.
module rrp_stream_merger #(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 32,
  parameter int ID_BITS   = 3,
  parameter int MAX_BURST = 16,
  parameter int TAG_EN    = 1
) (
  input  logic                     BUS_CLK,
  input  logic                     BUS_RST,
  input  logic [N_CH-1:0]          CH_EN,
  input  logic [N_CH-1:0]          CH_WRITE,
  input  logic [N_CH*DATA_W-1:0]   CH_DATA,
  output logic [N_CH-1:0]          CH_READ,
  input  logic                     FIFO_FULL,
  input  logic                     ARB_READY_OUT,
  output logic                     ARB_WRITE_OUT,
  output logic [DATA_W-1:0]        ARB_DATA_OUT,
  output logic [ID_BITS-1:0]       GRANT_ID,
  output logic [31:0]              WORD_CNT
);
  localparam int                PTR_W     = $clog2(N_CH);
  localparam int                CNT_W     = 8;
  localparam logic [PTR_W-1:0]  PTR_RST   = PTR_W'(N_CH - 1);
  localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(MAX_BURST);

  function automatic logic [DATA_W-1:0] f_tag(input logic [DATA_W-1:0] d,
                                               input logic [PTR_W-1:0]  id);
    logic [DATA_W-1:0] t;
    t = d;
    if (TAG_EN != 0) t[DATA_W-1 -: ID_BITS] = ID_BITS'(id);
    return t;
  endfunction

  function automatic logic [31:0] f_sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic                r_vld_p1;
  logic [DATA_W-1:0]   r_data_p1;
  logic [ID_BITS-1:0]  r_gid_p1;
  logic [31:0]         r_word_cnt;
  logic [CNT_W-1:0]    r_burst_cnt;
  logic                r_own_vld;
  logic [PTR_W-1:0]    r_owner;
  logic [PTR_W-1:0]    r_ptr;

  logic [N_CH-1:0]     w_req;
  logic                w_keep;
  logic                w_sel_vld;
  logic [PTR_W-1:0]    w_sel;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_pop;
  logic                w_load;

  assign w_req  = CH_WRITE & CH_EN;
  assign w_keep = r_own_vld && w_req[r_owner] && (r_burst_cnt < BURST_MAX);

  // Stage p0: selection. Descending scan so the nearest requester after r_ptr wins.
  always_comb begin
    logic [PTR_W-1:0] v_idx;
    v_idx     = '0;
    w_sel     = r_owner;
    w_sel_vld = w_keep;
    if (!w_keep) begin
      for (int k = N_CH; k >= 1; k--) begin
        v_idx = PTR_W'((int'(r_ptr) + k) % N_CH);
        if (w_req[v_idx]) begin
          w_sel     = v_idx;
          w_sel_vld = 1'b1;
        end
      end
    end
  end

  assign w_sel_data = CH_DATA[int'(w_sel)*DATA_W +: DATA_W];
  assign w_pop      = ARB_READY_OUT & r_vld_p1;
  assign w_load     = (!r_vld_p1 | w_pop) & w_sel_vld & !FIFO_FULL & !BUS_RST;

  always_comb begin
    CH_READ = '0;
    if (w_load) CH_READ[w_sel] = 1'b1;
  end

  // Stage p1: output register and arbitration state.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_vld_p1    <= 1'b0;
      r_data_p1   <= '0;
      r_gid_p1    <= '0;
      r_word_cnt  <= '0;
      r_burst_cnt <= '0;
      r_own_vld   <= 1'b0;
      r_owner     <= '0;
      r_ptr       <= PTR_RST;
    end else if (w_load) begin
      r_vld_p1    <= 1'b1;
      r_data_p1   <= f_tag(w_sel_data, w_sel);
      r_gid_p1    <= ID_BITS'(w_sel);
      r_ptr       <= w_sel;
      r_owner     <= w_sel;
      r_own_vld   <= 1'b1;
      r_burst_cnt <= w_keep ? r_burst_cnt + CNT_W'(1) : CNT_W'(1);
      r_word_cnt  <= f_sat_inc(r_word_cnt);
    end else begin
      if (w_pop) r_vld_p1 <= 1'b0;
      // Owner lost its request or exhausted its burst: hand the grant back.
      if (r_own_vld && !w_keep) r_own_vld <= 1'b0;
    end
  end

  assign ARB_WRITE_OUT = r_vld_p1;
  assign ARB_DATA_OUT  = r_data_p1;
  assign GRANT_ID      = r_gid_p1;
  assign WORD_CNT      = r_word_cnt;

endmodule

// File: tb/tb_rrp_stream_merger.sv
// Directed scoreboard bench for rrp_stream_merger: u0 (MAX_BURST=2, tagged), u1 (MAX_BURST=1, untagged).
module tb_rrp_stream_merger;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    en0, wr0, rd0;
  logic [N*DW-1:0] data0;
  logic            full0, rdy0, aw0;
  logic [DW-1:0]   ad0;
  logic [IB-1:0]   gid0;
  logic [31:0]     wc0;

  logic [N-1:0]    en1, wr1, rd1;
  logic [N*DW-1:0] data1;
  logic            full1, rdy1, aw1;
  logic [DW-1:0]   ad1;
  logic [IB-1:0]   gid1;
  logic [31:0]     wc1;

  rrp_stream_merger #(.N_CH(N), .DATA_W(DW), .ID_BITS(IB), .MAX_BURST(2), .TAG_EN(1)) u0 (
    .BUS_CLK(clk), .BUS_RST(rst), .CH_EN(en0), .CH_WRITE(wr0), .CH_DATA(data0),
    .CH_READ(rd0), .FIFO_FULL(full0), .ARB_READY_OUT(rdy0), .ARB_WRITE_OUT(aw0),
    .ARB_DATA_OUT(ad0), .GRANT_ID(gid0), .WORD_CNT(wc0));

  rrp_stream_merger #(.N_CH(N), .DATA_W(DW), .ID_BITS(IB), .MAX_BURST(1), .TAG_EN(0)) u1 (
    .BUS_CLK(clk), .BUS_RST(rst), .CH_EN(en1), .CH_WRITE(wr1), .CH_DATA(data1),
    .CH_READ(rd1), .FIFO_FULL(full1), .ARB_READY_OUT(rdy1), .ARB_WRITE_OUT(aw1),
    .ARB_DATA_OUT(ad1), .GRANT_ID(gid1), .WORD_CNT(wc1));

  // Source model for u0: per-channel word count and sequence number advanced by CH_READ.
  int          avail[N];
  int          seq[N];
  logic        ones0;
  logic [31:0] d1[N];

  function automatic logic [31:0] src_word(input int i, input int s);
    return 32'h0A00_0000 | (32'(i) << 16) | (32'(s) & 32'h0000_FFFF);
  endfunction

  function automatic logic [31:0] exp_tag(input logic [31:0] w, input int i);
    logic [31:0] t;
    t = w;
    t[31:29] = i[2:0];
    return t;
  endfunction

  always_comb begin
    wr0   = '0;
    data0 = '0;
    data1 = '0;
    for (int i = 0; i < N; i++) begin
      wr0[i]           = (avail[i] > 0);
      data0[i*DW +: DW] = ones0 ? 32'hFFFF_FFFF : src_word(i, seq[i]);
      data1[i*DW +: DW] = d1[i];
    end
  end

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  g;
  } exp_t;

  exp_t        sbq[$];
  int          exp_seq[N];
  int          n_vec = 0;
  int          n_err = 0;
  logic [N-1:0] last_rd0, last_rd1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ch(input int ch);
    exp_t e;
    e.d = exp_tag(src_word(ch, exp_seq[ch]), ch);
    e.g = 3'(ch);
    sbq.push_back(e);
    exp_seq[ch]++;
  endtask

  task automatic push_lit(input logic [31:0] d, input logic [2:0] g);
    exp_t e;
    e.d = d;
    e.g = g;
    sbq.push_back(e);
  endtask

  // One clock: compare a popped word at the start, sample strobes, advance sources after the edge.
  task automatic cyc();
    exp_t e;
    if (aw0 && rdy0) begin
      n_vec++;
      assert (sbq.size() > 0) else begin
        n_err++;
        $error("FAIL sb_unexpected observed=%0h expected=none", ad0);
      end
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_data", 64'(ad0), 64'(e.d));
        chk("sb_gid", 64'(gid0), 64'(e.g));
      end
    end
    #1;
    last_rd0 = rd0;
    last_rd1 = rd1;
    chk("rd0_onehot", 64'($countones(last_rd0) <= 1), 64'(1'b1));
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (last_rd0[i]) begin
        seq[i]++;
        avail[i]--;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((sbq.size() > 0 || aw0) && k < 40) begin
      cyc();
      k++;
    end
    chk({tag, "_drained"}, 64'(sbq.size()), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rd0", 64'(rd0), 64'(0));
    @(posedge clk);
    #1;
    sbq.delete();
    for (int i = 0; i < N; i++) begin
      seq[i]     = 0;
      exp_seq[i] = 0;
      avail[i]   = 0;
    end
    @(negedge clk);
    chk("rst_aw0", 64'(aw0), 64'(0));
    chk("rst_ad0", 64'(ad0), 64'(0));
    chk("rst_gid0", 64'(gid0), 64'(0));
    chk("rst_wc0", 64'(wc0), 64'(0));
    chk("rst_aw1", 64'(aw1), 64'(0));
    chk("rst_wc1", 64'(wc1), 64'(0));
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t5_exp[7];
    t5_exp = '{0, 2, 3, 0, 2, 3, 0};
    rst   = 1'b1;
    en0   = 4'b1111;  full0 = 1'b0; rdy0 = 1'b1; ones0 = 1'b0;
    en1   = 4'b1111;  wr1   = '0;   full1 = 1'b0; rdy1 = 1'b1;
    for (int i = 0; i < N; i++) d1[i] = '0;
    @(negedge clk);
    do_reset();

    // Test 1: ch0 only, three words, READY high.
    avail[0] = 3;
    for (int i = 0; i < 3; i++) push_ch(0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t1_rd", 64'(last_rd0), (k < 3) ? 64'(1) : 64'(0));
      chk("t1_aw", 64'(aw0), (k < 3) ? 64'(1) : 64'(0));
    end
    chk("t1_wc", 64'(wc0), 64'(3));
    chk("t1_empty", 64'(sbq.size()), 64'(0));

    // Test 2: bursts of two rotating over all channels.
    do_reset();
    avail[0] = 4; avail[1] = 2; avail[2] = 2; avail[3] = 2;
    push_ch(0); push_ch(0); push_ch(1); push_ch(1); push_ch(2);
    push_ch(2); push_ch(3); push_ch(3); push_ch(0); push_ch(0);
    drain("t2");
    chk("t2_wc", 64'(wc0), 64'(10));

    // Test 3: FIFO_FULL blocks loads, held word stays stable, then pop+load with no bubble.
    do_reset();
    rdy0 = 1'b0; full0 = 1'b1; avail[1] = 2;
    push_ch(1); push_ch(1);
    cyc();
    chk("t3_full_rd", 64'(last_rd0), 64'(0));
    chk("t3_full_aw", 64'(aw0), 64'(0));
    full0 = 1'b0;
    cyc();
    chk("t3_load_rd", 64'(last_rd0), 64'(4'b0010));
    chk("t3_load_aw", 64'(aw0), 64'(1));
    full0 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t3_hold_aw", 64'(aw0), 64'(1));
      chk("t3_hold_data", 64'(ad0), 64'(sbq[0].d));
      chk("t3_hold_rd", 64'(last_rd0), 64'(0));
    end
    full0 = 1'b0; rdy0 = 1'b1;
    cyc();
    chk("t3_swap_rd", 64'(last_rd0), 64'(4'b0010));
    chk("t3_swap_aw", 64'(aw0), 64'(1));
    chk("t3_swap_data", 64'(ad0), 64'(sbq[0].d));
    drain("t3");

    // Test 4: all-ones word on ch2, tagged on u0 and untagged on u1.
    do_reset();
    ones0 = 1'b1; avail[2] = 1;
    push_lit(32'h5FFF_FFFF, 3'd2);
    for (int i = 0; i < N; i++) d1[i] = 32'hFFFF_FFFF;
    wr1 = 4'b0100;
    cyc();
    wr1 = 4'b0000;
    chk("t4_u1_aw", 64'(aw1), 64'(1));
    chk("t4_u1_data", 64'(ad1), 64'(32'hFFFF_FFFF));
    chk("t4_u1_gid", 64'(gid1), 64'(2));
    drain("t4");
    ones0 = 1'b0;

    // Test 5: channel 1 masked, single-word bursts on u1.
    do_reset();
    for (int i = 0; i < N; i++) d1[i] = 32'h1111_1111 * 32'(i + 1);
    en1 = 4'b1101; wr1 = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("t5_rd1", 64'(last_rd1), 64'(4'b0001 << t5_exp[k]));
      chk("t5_gid1", 64'(gid1), 64'(t5_exp[k]));
      chk("t5_data1", 64'(ad1), 64'(32'h1111_1111 * 32'(t5_exp[k] + 1)));
    end
    wr1 = 4'b0000;
    cyc();

    // Test 6: reset in the middle of a ch3 burst, then restart from channel 0.
    do_reset();
    avail[3] = 10;
    push_ch(3); push_ch(3); push_ch(3);
    cyc(); cyc(); cyc();
    chk("t6_pre_aw", 64'(aw0), 64'(1));
    do_reset();
    for (int i = 0; i < N; i++) avail[i] = 2;
    push_ch(0); push_ch(0); push_ch(1); push_ch(1);
    push_ch(2); push_ch(2); push_ch(3); push_ch(3);
    cyc();
    chk("t6_first_gid", 64'(gid0), 64'(0));
    drain("t6");
    chk("t6_wc", 64'(wc0), 64'(8));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
